// File: rtl/arbiter_vc_dest.sv
// -----------------------------------------------------------------------------
// arbiter_vc_dest
//
// Arbitration and routing stage that sits directly behind the two virtual-
// channel FIFOs. Each cycle it pops at most one word, with vc0 strictly ahead
// of vc1. The popped word arrives on data_mux_* one cycle later. It is then
// steered, one cycle after that, to destination d0 or d1 by bit DEST_BIT of
// the word. Destination back-pressure stalls popping. Upstream FIFO errors
// park the block in a sticky ERROR state until reset.
//
// Ports
//   clk, reset_L                  clock, asynchronous active-low reset
//   fifo_empty_vc0/1              VC FIFO empty flags
//   fifo_error_vc0/1              VC FIFO error flags
//   data_mux_0/1   [DATA_SIZE]    VC FIFO pop data, valid the cycle after a pop
//   fifo_pause_d0/1               destination almost-full back-pressure
//   pop_vc0/1                     pop strobes (combinational, one-hot or zero)
//   push_d0/1                     destination push strobes (registered)
//   data_d0/1      [DATA_SIZE]    destination push data (registered, held)
//   cnt_d0/1       [COUNT_W]      words pushed per destination, wraps
//   arb_error                     sticky error flag
//   state          [2]            RESET=0, IDLE=1, ACTIVE=2, ERROR=3
// -----------------------------------------------------------------------------
module arbiter_vc_dest #(
    parameter int DATA_SIZE = 6,
    parameter int DEST_BIT  = 4,
    parameter int COUNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 fifo_empty_vc0,
    input  logic                 fifo_empty_vc1,
    input  logic                 fifo_error_vc0,
    input  logic                 fifo_error_vc1,
    input  logic [DATA_SIZE-1:0] data_mux_0,
    input  logic [DATA_SIZE-1:0] data_mux_1,
    input  logic                 fifo_pause_d0,
    input  logic                 fifo_pause_d1,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_d0,
    output logic [DATA_SIZE-1:0] data_d1,
    output logic [COUNT_W-1:0]   cnt_d0,
    output logic [COUNT_W-1:0]   cnt_d1,
    output logic                 arb_error,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 go;
    logic                 any_error;
    logic                 inflight;   // a word was popped last cycle
    logic                 sel;        // that word came from vc1
    logic [DATA_SIZE-1:0] word;

    assign any_error = fifo_error_vc0 | fifo_error_vc1;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (any_error) begin
                    state_d = ST_ERROR;
                end else if (!fifo_empty_vc0 || !fifo_empty_vc1) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (any_error) begin
                    state_d = ST_ERROR;
                end else if (fifo_empty_vc0 && fifo_empty_vc1 && !inflight) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    assign state     = state_q;
    assign arb_error = (state_q == ST_ERROR);

    // -------------------------------------------------------------------------
    // Pop generation
    // -------------------------------------------------------------------------
    // Either pause stalls both VCs: the destination of a word is only known
    // once it has been popped, so it cannot be filtered per destination.
    assign go = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE))
                && !fifo_pause_d0 && !fifo_pause_d1;

    assign pop_vc0 = go && !fifo_empty_vc0;
    assign pop_vc1 = go && fifo_empty_vc0 && !fifo_empty_vc1;

    // -------------------------------------------------------------------------
    // Routing datapath
    // -------------------------------------------------------------------------
    assign word = sel ? data_mux_1 : data_mux_0;

    // The in-flight word is routed regardless of state or pause: the FIFO has
    // already released it, and the destinations reserve headroom for it.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            inflight <= 1'b0;
            sel      <= 1'b0;
            push_d0  <= 1'b0;
            push_d1  <= 1'b0;
            data_d0  <= '0;
            data_d1  <= '0;
            cnt_d0   <= '0;
            cnt_d1   <= '0;
        end else begin
            inflight <= pop_vc0 | pop_vc1;
            sel      <= pop_vc1;
            push_d0  <= 1'b0;
            push_d1  <= 1'b0;
            if (inflight) begin
                if (!word[DEST_BIT]) begin
                    data_d0 <= word;
                    push_d0 <= 1'b1;
                    cnt_d0  <= cnt_d0 + COUNT_W'(1);
                end else begin
                    data_d1 <= word;
                    push_d1 <= 1'b1;
                    cnt_d1  <= cnt_d1 + COUNT_W'(1);
                end
            end
        end
    end

endmodule
